// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK modem chain:
// deframer state encoding and frame-length decode.
package fsk_pkg;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_PAYLOAD = 1'b1
  } dfr_state_e;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 9;

  // A length byte of zero encodes a full 256-byte frame.
  function automatic logic [LEN_W-1:0] frame_len(
    input logic [7:0] len
  );
    if (len == 8'd0) return 9'd256;
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/fsk_bit_timing.sv
// Bit-timing recovery: registers the line, detects edges and
// emits one mid-bit sample strobe per bit period.
module fsk_bit_timing #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic [CNT_W-1:0] bit_period,
  output logic             bit_s,
  output logic             bit_edge,
  output logic             sample
);

  logic             bit_q, bit_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             period_ok;
  logic [CNT_W-1:0] half;

  always_comb begin
    bit_d     = bit_in;
    prev_d    = bit_q;
    period_ok = bit_period >= CNT_W'(2);
    half      = bit_period >> 1;
    bit_edge  = bit_q != prev_q;
    phase_d   = phase_q + CNT_W'(1);
    // >= also recovers when bit_period shrinks below the phase.
    if (!period_ok || bit_edge)
      phase_d = '0;
    else if (phase_q >= bit_period - CNT_W'(1))
      phase_d = '0;
    sample = period_ok && (phase_q == half);
    bit_s  = bit_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q   <= 1'b0;
      prev_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      bit_q   <= bit_d;
      prev_q  <= prev_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/fsk_bit_deframer.sv
// Sync-word hunt and payload byte assembly for the FSK
// receiver, with a valid/ready byte output.
module fsk_bit_deframer
  import fsk_pkg::*;
#(
  parameter int SYNC_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              bb_clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic [CNT_W-1:0]  bit_period,
  input  logic [SYNC_W-1:0] sync_word,
  input  logic [7:0]        payload_len,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              locked,
  output logic              frame_done,
  output logic              overrun
);

  dfr_state_e        state_q, state_d;
  logic [SYNC_W-1:0] sync_q, sync_d;
  logic [7:0]        data_q, data_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [LEN_W-1:0]  ycnt_q, ycnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [7:0]        out_q, out_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;

  logic              bit_s;
  logic              sample;
  logic              edge_unused;
  logic [CNT_W-1:0]  eff_period;

  // The bit period is frozen for the duration of a frame.
  assign eff_period = (state_q == ST_HUNT) ? bit_period
                                           : period_q;

  fsk_bit_timing #(
    .CNT_W (CNT_W)
  ) u_timing (
    .clk        (bb_clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_period (eff_period),
    .bit_s      (bit_s),
    .bit_edge   (edge_unused),
    .sample     (sample)
  );

  always_comb begin
    state_d  = state_q;
    sync_d   = sync_q;
    data_d   = data_q;
    bcnt_d   = bcnt_q;
    ycnt_d   = ycnt_q;
    len_d    = len_q;
    period_d = eff_period;
    out_d    = out_q;
    valid_d  = valid_q;
    locked_d = locked_q;
    done_d   = 1'b0;
    ovr_d    = ovr_q;

    if (valid_q && byte_ready)
      valid_d = 1'b0;

    if (sample) begin
      unique case (state_q)
        ST_HUNT: begin
          sync_d = {sync_q[SYNC_W-2:0], bit_s};
          if (sync_d == sync_word) begin
            state_d  = ST_PAYLOAD;
            locked_d = 1'b1;
            bcnt_d   = '0;
            ycnt_d   = '0;
            data_d   = '0;
            len_d    = frame_len(payload_len);
          end
        end
        ST_PAYLOAD: begin
          data_d = {data_q[6:0], bit_s};
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            if (valid_q && !byte_ready) begin
              ovr_d = 1'b1;
            end else begin
              out_d   = data_d;
              valid_d = 1'b1;
            end
            ycnt_d = ycnt_q + 9'd1;
            if (ycnt_d == len_q) begin
              state_d  = ST_HUNT;
              locked_d = 1'b0;
              done_d   = 1'b1;
              sync_d   = '0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge bb_clk) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      sync_q   <= '0;
      data_q   <= '0;
      bcnt_q   <= '0;
      ycnt_q   <= '0;
      len_q    <= '0;
      period_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      data_q   <= data_d;
      bcnt_q   <= bcnt_d;
      ycnt_q   <= ycnt_d;
      len_q    <= len_d;
      period_q <= period_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign byte_out   = out_q;
  assign byte_valid = valid_q;
  assign locked     = locked_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_fsk_bit_deframer.sv
// Scoreboard bench for fsk_bit_deframer: directed frames,
// overrun, mid-frame reset, jitter and length boundaries.
module tb_fsk_bit_deframer;

  logic        bb_clk = 1'b0;
  logic        rst;
  logic        bit_in;
  logic [15:0] bit_period;
  logic [15:0] sync_word;
  logic [7:0]  payload_len;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        locked;
  logic        frame_done;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  bit lock_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];

  always #5 bb_clk = ~bb_clk;

  fsk_bit_deframer #(
    .SYNC_W (16),
    .CNT_W  (16)
  ) dut (
    .bb_clk      (bb_clk),
    .rst         (rst),
    .bit_in      (bit_in),
    .bit_period  (bit_period),
    .sync_word   (sync_word),
    .payload_len (payload_len),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .locked      (locked),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte.
  always @(negedge bb_clk) begin
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (locked) lock_seen = 1;
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %0h want none",
                   byte_out);
        end else begin
          check("byte", {24'h0, byte_out}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  function automatic int blen(input int p, input int jit);
    if (jit == 0) return p;
    return p + int'($urandom_range(2 * jit, 0)) - jit;
  endfunction

  task automatic send_bit(input logic b, input int len);
    bit_in = b;
    repeat (len) @(negedge bb_clk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n,
                           input int p, input int jit);
    for (int i = n - 1; i >= 0; i--)
      send_bit(v[i], blen(p, jit));
  endtask

  task automatic send_frame(input int p, input int jit,
                            input int rnd_pre, input bit expect_rx);
    if (rnd_pre > 0) begin
      for (int i = 0; i < rnd_pre; i++)
        send_bit(1'($urandom_range(1, 0)), blen(p, jit));
    end else begin
      send_bits(16'h00AA, 8, p, jit);
    end
    send_bits(sync_word, 16, p, jit);
    foreach (tx_q[i]) begin
      if (expect_rx) exp_q.push_back(tx_q[i]);
      send_bits({8'h00, tx_q[i]}, 8, p, jit);
    end
    repeat (2 * p) @(negedge bb_clk);
    bit_in = 1'b0;
    repeat (2 * p) @(negedge bb_clk);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_byte_out"}, {24'h0, byte_out}, 32'h0);
    check({tag, "_valid"}, {31'h0, byte_valid}, 32'h0);
    check({tag, "_locked"}, {31'h0, locked}, 32'h0);
    check({tag, "_done"}, {31'h0, frame_done}, 32'h0);
    check({tag, "_overrun"}, {31'h0, overrun}, 32'h0);
  endtask

  task automatic frame_end(input string tag, input int fd0);
    check({tag, "_lock_seen"}, {31'h0, lock_seen}, 32'h1);
    check({tag, "_frame_done"}, fd_cnt - fd0, 32'd1);
    check({tag, "_unlocked"}, {31'h0, locked}, 32'h0);
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    lock_seen = 0;
  endtask

  initial begin
    int bad;
    int fd0;
    logic [15:0] pat;
    rst = 1'b1;
    bit_in = 1'b0;
    byte_ready = 1'b1;
    bit_period = 16'd3600;
    sync_word = 16'hA55A;
    payload_len = 8'd2;
    repeat (3) @(negedge bb_clk);
    rst = 1'b0;
    check_zero("reset");

    bad = 0;
    repeat (20000) begin
      @(negedge bb_clk);
      if (byte_valid || locked) bad++;
    end
    check("idle_quiet", bad, 0);
    lock_seen = 0;

    bit_period = 16'd20;
    tx_q = '{8'h3C, 8'hC3};
    fd0 = fd_cnt;
    send_frame(20, 0, 0, 1);
    frame_end("basic", fd0);

    byte_ready = 1'b0;
    send_frame(20, 0, 0, 0);
    check("ovr_valid_held", {31'h0, byte_valid}, 32'h1);
    check("ovr_byte_out", {24'h0, byte_out}, 32'h3C);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    check("ovr_unlocked", {31'h0, locked}, 32'h0);
    rst = 1'b1;
    @(negedge bb_clk);
    rst = 1'b0;
    byte_ready = 1'b1;
    check_zero("ovr_reset");
    lock_seen = 0;

    payload_len = 8'd4;
    tx_q = '{8'hA5, 8'h5A, 8'h11, 8'h22};
    fd0 = fd_cnt;
    send_frame(20, 0, 0, 1);
    frame_end("sync_in_data", fd0);

    payload_len = 8'd2;
    send_bits(16'h00AA, 8, 20, 0);
    send_bits(sync_word, 16, 20, 0);
    send_bits(16'h0003, 4, 20, 0);
    check("mid_locked", {31'h0, locked}, 32'h1);
    rst = 1'b1;
    @(negedge bb_clk);
    rst = 1'b0;
    check_zero("mid_reset");
    bit_in = 1'b0;
    repeat (40) @(negedge bb_clk);
    lock_seen = 0;
    tx_q = '{8'h3C, 8'hC3};
    fd0 = fd_cnt;
    send_frame(20, 0, 0, 1);
    frame_end("after_reset", fd0);

    bit_period = 16'd40;
    tx_q = '{8'h96, 8'h0F};
    fd0 = fd_cnt;
    send_frame(40, 2, 37, 1);
    frame_end("jitter", fd0);

    bit_period = 16'd1;
    bad = 0;
    pat = sync_word;
    for (int i = 0; i < 320; i++) begin
      bit_in = pat[15 - (i % 16)];
      @(negedge bb_clk);
      if (byte_valid || locked) bad++;
    end
    check("short_period_hunt", bad, 0);
    bit_in = 1'b0;
    lock_seen = 0;

    bit_period = 16'd8;
    payload_len = 8'd0;
    tx_q.delete();
    for (int i = 0; i < 256; i++)
      tx_q.push_back(8'(i * 37 + 5));
    fd0 = fd_cnt;
    send_frame(8, 0, 0, 1);
    frame_end("len256", fd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
